// File: rtl/taylor_asin_pkg.sv
// Package for the arcsin series evaluator.
// Holds the IEEE754 single-precision series coefficients, the common
// float constants, the FSM state type and a coefficient lookup helper.
// No ports; imported by every file of the block.
package taylor_asin_pkg;

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    // c(2k+1) = (2k-1)!! / ((2k)!! * (2k+1)), rounded to nearest float.
    localparam logic [31:0] ASIN_C1  = 32'h3F800000; // 1
    localparam logic [31:0] ASIN_C3  = 32'h3E2AAAAB; // 1/6
    localparam logic [31:0] ASIN_C5  = 32'h3D99999A; // 3/40
    localparam logic [31:0] ASIN_C7  = 32'h3D36DB6E; // 15/336
    localparam logic [31:0] ASIN_C9  = 32'h3CF8E38E; // 105/3456
    localparam logic [31:0] ASIN_C11 = 32'h3CB745D1; // 945/42240
    localparam logic [31:0] ASIN_C13 = 32'h3C8E2762; // 10395/599040

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQR   = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } asin_state_t;

    // Coefficient of x^(2k+1).
    function automatic logic [31:0] asin_coef(input logic [2:0] k);
        logic [31:0] c;
        case (k)
            3'd0:    c = ASIN_C1;
            3'd1:    c = ASIN_C3;
            3'd2:    c = ASIN_C5;
            3'd3:    c = ASIN_C7;
            3'd4:    c = ASIN_C9;
            3'd5:    c = ASIN_C11;
            3'd6:    c = ASIN_C13;
            default: c = FP_ONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/taylor_asin_if.sv
// Request/response bundle of the arcsin evaluator.
//   start   : request, sampled only while idle
//   in      : IEEE754 operand x, captured with start
//   busy    : evaluation in progress
//   done    : one-cycle pulse, out/dom_err valid
//   out     : IEEE754 arcsin(x), held until the next done
//   dom_err : |x|>1, Inf or NaN on the finished request
// master = requester side, slave = evaluator side.
interface taylor_asin_if;
    logic        start;
    logic [31:0] in;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        dom_err;

    modport master (output start, in, input busy, done, out, dom_err);
    modport slave  (input start, in, output busy, done, out, dom_err);
endinterface

// File: rtl/taylor_asin_fp.sv
// Combinational single-precision arithmetic shared by the evaluator.
//   nhan     : y = a * b
//   cong_tru : y = a + b (operation=0) or a - b (operation=1)
// Round to nearest even; subnormal operands and results flush to
// signed zero; NaN/Inf follow the usual IEEE754 rules with a quiet
// NaN of 32'h7FC00000.
module nhan
    import taylor_asin_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic               sign_s;
    logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic [47:0]        prod_s;
    logic [22:0]        frac_s;
    logic               guard_s, sticky_s;
    logic [23:0]        rnd_s;
    logic signed [10:0] exp_s;
    logic signed [10:0] exp_r_s;

    // Mantissa product, normalisation, rounding and special cases.
    always_comb begin
        sign_s   = a[31] ^ b[31];
        a_zero_s = (a[30:23] == 8'h00);
        b_zero_s = (b[30:23] == 8'h00);
        a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod_s   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (prod_s[47]) begin
            frac_s   = prod_s[46:24];
            guard_s  = prod_s[23];
            sticky_s = |prod_s[22:0];
            exp_s    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd126;
        end else begin
            frac_s   = prod_s[45:23];
            guard_s  = prod_s[22];
            sticky_s = |prod_s[21:0];
            exp_s    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        end
        rnd_s = {1'b0, frac_s} + {23'd0, guard_s & (sticky_s | frac_s[0])};
        // Rounding carry out of the mantissa means 2.0: bump the exponent.
        if (rnd_s[23]) begin
            exp_r_s = exp_s + 11'sd1;
        end else begin
            exp_r_s = exp_s;
        end
        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            y = FP_QNAN;
        end else if (a_inf_s || b_inf_s) begin
            y = {sign_s, 8'hFF, 23'd0};
        end else if (a_zero_s || b_zero_s) begin
            y = {sign_s, 31'd0};
        end else if (exp_r_s >= 11'sd255) begin
            y = {sign_s, 8'hFF, 23'd0};
        end else if (exp_r_s <= 11'sd0) begin
            y = {sign_s, 31'd0};
        end else begin
            y = {sign_s, exp_r_s[7:0], rnd_s[22:0]};
        end
    end
endmodule

module cong_tru
    import taylor_asin_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        operation,
    output logic [31:0] y
);
    logic               sb_s;
    logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic               big_sign_s, sml_sign_s;
    logic [30:0]        big_s, sml_s;
    logic [26:0]        m_big_s, m_sml_s, m_al_s;
    logic [7:0]         d_s;
    logic [4:0]         dcap_s;
    logic [53:0]        sh_s;
    logic [27:0]        sum_s;
    logic [26:0]        norm_s;
    logic [4:0]         lz_s;
    logic signed [10:0] exp_s;
    logic [23:0]        rnd_s;
    logic signed [10:0] exp_r_s;

    // Align the smaller operand, add/subtract, renormalise and round.
    always_comb begin
        sb_s     = b[31] ^ operation;
        a_zero_s = (a[30:23] == 8'h00);
        b_zero_s = (b[30:23] == 8'h00);
        a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        // Larger magnitude first so the subtraction never goes negative.
        if (a[30:0] >= b[30:0]) begin
            big_s = a[30:0]; big_sign_s = a[31];
            sml_s = b[30:0]; sml_sign_s = sb_s;
        end else begin
            big_s = b[30:0]; big_sign_s = sb_s;
            sml_s = a[30:0]; sml_sign_s = a[31];
        end
        // Three extra low bits carry guard, round and sticky information.
        m_big_s = {1'b1, big_s[22:0], 3'b000};
        if (sml_s[30:23] == 8'h00) begin
            m_sml_s = 27'd0;
        end else begin
            m_sml_s = {1'b1, sml_s[22:0], 3'b000};
        end
        d_s    = big_s[30:23] - sml_s[30:23];
        dcap_s = (d_s > 8'd27) ? 5'd27 : d_s[4:0];
        sh_s   = {m_sml_s, 27'd0} >> dcap_s;
        m_al_s = {sh_s[53:28], sh_s[27] | (|sh_s[26:0])};
        if (big_sign_s == sml_sign_s) begin
            sum_s = {1'b0, m_big_s} + {1'b0, m_al_s};
        end else begin
            sum_s = {1'b0, m_big_s} - {1'b0, m_al_s};
        end
        lz_s = 5'd0;
        for (int i = 0; i < 27; i++) begin
            lz_s = sum_s[i] ? 5'(26 - i) : lz_s;
        end
        if (sum_s[27]) begin
            norm_s = sum_s[27:1] | {26'd0, sum_s[0]};
            exp_s  = $signed({3'b000, big_s[30:23]}) + 11'sd1;
        end else begin
            norm_s = sum_s[26:0] << lz_s;
            exp_s  = $signed({3'b000, big_s[30:23]}) - $signed({6'b000000, lz_s});
        end
        rnd_s = {1'b0, norm_s[25:3]} + {23'd0, norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3])};
        if (rnd_s[23]) begin
            exp_r_s = exp_s + 11'sd1;
        end else begin
            exp_r_s = exp_s;
        end
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a[31] != sb_s))) begin
            y = FP_QNAN;
        end else if (a_inf_s) begin
            y = a;
        end else if (b_inf_s) begin
            y = {sb_s, b[30:0]};
        end else if (b_zero_s) begin
            y = a_zero_s ? {a[31] & sb_s, 31'd0} : a;
        end else if (a_zero_s) begin
            y = {sb_s, b[30:0]};
        end else if (sum_s == 28'd0) begin
            y = 32'h00000000;
        end else if (exp_r_s >= 11'sd255) begin
            y = {big_sign_s, 8'hFF, 23'd0};
        end else if (exp_r_s <= 11'sd0) begin
            y = {big_sign_s, 31'd0};
        end else begin
            y = {big_sign_s, exp_r_s[7:0], rnd_s[22:0]};
        end
    end
endmodule

// File: rtl/taylor_asin.sv
// arcsin(x) for IEEE754 single precision by Maclaurin series,
// evaluated in Horner form with one shared multiplier and adder:
//   asin x = x*(c1 + x2*(c3 + x2*(c5 + ... + x2*c(2N-1)))), x2 = x*x
// Fixed latency of 2*NTERMS cycles from the accepted start edge to done.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any evaluation
//   bus  : taylor_asin_if.slave (start/in request, busy/done/out/dom_err)
// Parameter NTERMS (1..7): number of odd-power terms x^1..x^(2N-1).
module taylor_asin
    import taylor_asin_pkg::*;
#(
    parameter int NTERMS = 7
) (
    input  logic          clk,
    input  logic          rst,
    taylor_asin_if.slave  bus
);
    localparam logic [2:0] K_TOP  = 3'(NTERMS - 1);
    localparam logic [2:0] K_INIT = (NTERMS >= 2) ? 3'(NTERMS - 2) : 3'd0;

    asin_state_t state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] x2_q, x2_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  k_q, k_d;
    logic        derr_q, derr_d;
    logic [31:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dom_err_q, dom_err_d;

    logic [31:0] mul_a_s, mul_b_s, mul_y_s;
    logic [31:0] coef_s, add_y_s;
    logic        in_dom_s;

    // Multiplier operand select; only one product is consumed per state.
    always_comb begin
        case (state_q)
            MUL: begin
                mul_a_s = acc_q;
                mul_b_s = x2_q;
            end
            FINAL: begin
                mul_a_s = acc_q;
                mul_b_s = x_q;
            end
            default: begin
                mul_a_s = x_q;
                mul_b_s = x_q;
            end
        endcase
    end

    assign coef_s = asin_coef(k_q);
    // Inf/NaN have the all-ones exponent and therefore also compare above 1.0.
    assign in_dom_s = (bus.in[30:23] == 8'hFF) || (bus.in[30:0] > 31'h3F800000);

    nhan u_nhan (
        .a (mul_a_s),
        .b (mul_b_s),
        .y (mul_y_s)
    );

    cong_tru u_cong_tru (
        .a         (acc_q),
        .b         (coef_s),
        .operation (1'b0),
        .y         (add_y_s)
    );

    // Sequencer: next-state and next-value logic for every register.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        x2_d      = x2_q;
        acc_d     = acc_q;
        k_d       = k_q;
        derr_d    = derr_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dom_err_d = dom_err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.in;
                    derr_d  = in_dom_s;
                    busy_d  = 1'b1;
                    state_d = SQR;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            SQR: begin
                x2_d  = mul_y_s;
                acc_d = asin_coef(K_TOP);
                k_d   = K_INIT;
                if (NTERMS == 1) begin
                    state_d = FINAL;
                end else begin
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d   = mul_y_s;
                state_d = ADD;
            end
            ADD: begin
                acc_d = add_y_s;
                if (k_q == 3'd0) begin
                    state_d = FINAL;
                end else begin
                    k_d     = k_q - 3'd1;
                    state_d = MUL;
                end
            end
            FINAL: begin
                // Sign of the result (including signed zero) comes from x here.
                out_d     = derr_q ? FP_QNAN : mul_y_s;
                dom_err_d = derr_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= 32'h0;
            x2_q      <= 32'h0;
            acc_q     <= 32'h0;
            k_q       <= 3'd0;
            derr_q    <= 1'b0;
            out_q     <= 32'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dom_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x2_q      <= x2_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            derr_q    <= derr_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dom_err_q <= dom_err_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out     = out_q;
    assign bus.dom_err = dom_err_q;

endmodule
